// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//   Single-port RAM controller that sits directly behind the SPI slave. It
//   takes 10-bit command words (opcode + payload) and keeps separate write and
//   read address pointers. RD_DATA commands return one byte on tx_data/tx_valid
//   for the slave to shift out. cmd_err is a sticky flag for protocol misuse.
//
// Ports
//   clk       in   1   rising-edge clock, shared with the SPI slave
//   rst       in   1   asynchronous assert, synchronous release, active high
//   rx_data   in   10  command word: [9:8] opcode, [7:0] payload
//   rx_valid  in   1   one-cycle strobe qualifying rx_data
//   tx_data   out  8   read data (holds last value while tx_valid=0)
//   tx_valid  out  1   one-cycle strobe, one cycle after an accepted RD_DATA
//   cmd_err   out  1   sticky error: data op without an address, or an opcode
//                      not legal in the current protocol state
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       cmd_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_ARMD = 2'd1,
      RD_ARMD = 2'd2,
      RD_RESP = 2'd3
   } state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   logic [7:0]           mem [MEM_DEPTH];

   state_t               state_reg, state_next;
   logic [ADDR_SIZE-1:0] wr_ptr_reg, rd_ptr_reg;
   logic                 wr_ptr_vld_reg, rd_ptr_vld_reg;

   logic [1:0]           opcode;
   logic [ADDR_SIZE-1:0] addr_payload;
   logic [7:0]           data_payload;
   logic                 do_write, do_read, op_legal, err_next;

   assign opcode       = rx_data[9:8];
   assign addr_payload = rx_data[ADDR_SIZE-1:0];
   assign data_payload = rx_data[7:0];

   // The pointer-valid flags alone decide whether memory is accessed; the
   // protocol state only affects cmd_err.
   assign do_write = rx_valid && (opcode == OP_WR_DATA) && wr_ptr_vld_reg;
   assign do_read  = rx_valid && (opcode == OP_RD_DATA) && rd_ptr_vld_reg;

   // Legal opcodes per state. RD_RESP accepts the same set as RD_ARMD so that
   // back-to-back reads and re-addressing after a read are allowed.
   always_comb begin
      op_legal = 1'b0;
      case (state_reg)
         IDLE:    op_legal = (opcode == OP_WR_ADDR) || (opcode == OP_RD_ADDR);
         WR_ARMD: op_legal = (opcode != OP_RD_DATA);
         RD_ARMD,
         RD_RESP: op_legal = (opcode != OP_WR_DATA);
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      err_next = 1'b0;
      if (rx_valid) begin
         err_next = !op_legal
                 || ((opcode == OP_WR_DATA) && !wr_ptr_vld_reg)
                 || ((opcode == OP_RD_DATA) && !rd_ptr_vld_reg);
      end
   end

   // Next state. An illegal data op that is still performed (its pointer is
   // valid) moves to the state matching the access, so a read always lands in
   // RD_RESP and produces exactly one tx_valid pulse.
   always_comb begin
      state_next = state_reg;
      if (rx_valid) begin
         case (opcode)
            OP_WR_ADDR: state_next = WR_ARMD;
            OP_RD_ADDR: state_next = RD_ARMD;
            OP_WR_DATA: if (do_write) state_next = WR_ARMD;
            OP_RD_DATA: if (do_read)  state_next = RD_RESP;
            default:    state_next = state_reg;
         endcase
      end else if (state_reg == RD_RESP) begin
         state_next = RD_ARMD;
      end
   end

   // RAM write port; never reset, contents survive rst.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr_reg] <= data_payload;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         wr_ptr_vld_reg <= 1'b0;
         rd_ptr_vld_reg <= 1'b0;
         tx_data        <= 8'h00;
         tx_valid       <= 1'b0;
         cmd_err        <= 1'b0;
      end else begin
         state_reg <= state_next;
         tx_valid  <= (state_next == RD_RESP);
         // Registered read port. A write on the previous edge is already in
         // the array, so write-then-read returns the new data.
         if (do_read) begin
            tx_data <= mem[rd_ptr_reg];
         end
         if (err_next) begin
            cmd_err <= 1'b1;
         end
         if (rx_valid && (opcode == OP_WR_ADDR)) begin
            wr_ptr_reg     <= addr_payload;
            wr_ptr_vld_reg <= 1'b1;
         end else if (do_write && (AUTO_INC != 0)) begin
            // MEM_DEPTH == 2**ADDR_SIZE, so natural overflow wraps to 0.
            wr_ptr_reg <= wr_ptr_reg + ADDR_SIZE'(1);
         end
         if (rx_valid && (opcode == OP_RD_ADDR)) begin
            rd_ptr_reg     <= addr_payload;
            rd_ptr_vld_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
module tb_spi_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       cmd_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];

   localparam logic [1:0] WA = 2'b00;
   localparam logic [1:0] WD = 2'b01;
   localparam logic [1:0] RA = 2'b10;
   localparam logic [1:0] RD = 2'b11;

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every tx_valid pulse must match the oldest expected response,
   // including the cycle it was due in.
   always @(negedge clk) begin
      if (tx_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx: got tx_data=%02h at cycle %0d, required no response", tx_data, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (tx_data !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL rd_resp: got %02h at cycle %0d, required %02h at cycle %0d",
                        tx_data, cyc, e.data, e.cyc);
            end else begin
               $display("resp ok: tx_data=%02h cycle %0d", tx_data, cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h, required %02h", name, act, exp);
      end
   endtask

   // Issue one command word; accepted on the next rising edge.
   task automatic cmd(input logic [1:0] op, input logic [7:0] pl,
                      input bit exp_resp, input logic [7:0] exp_data);
      exp_t e;
      rx_data  = {op, pl};
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      $display("cmd op=%0d payload=%02h cycle %0d expect_resp=%0d exp=%02h", op, pl, cyc, exp_resp, exp_data);
      if (exp_resp) begin
         e.data = exp_data;
         e.cyc  = cyc;
         sb_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // 1. Reset state, then RD_DATA with no read address latched
      do_reset();
      check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_cmd_err", {7'b0, cmd_err}, 8'h00);
      cmd(RD, 8'h00, 0, 8'h00);
      @(negedge clk);
      check("rd_noaddr_err", {7'b0, cmd_err}, 8'h01);

      // 2. Basic write then read
      do_reset();
      cmd(WA, 8'h12, 0, 8'h00);
      cmd(WD, 8'hA5, 0, 8'h00);
      cmd(RA, 8'h12, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'hA5);
      @(negedge clk);
      @(negedge clk);
      check("t2_valid_drop", {7'b0, tx_valid}, 8'h00);
      check("t2_data_hold", tx_data, 8'hA5);
      check("t2_cmd_err", {7'b0, cmd_err}, 8'h00);

      // 3. Auto-increment wraps 0xFF -> 0x00
      cmd(WA, 8'hFF, 0, 8'h00);
      cmd(WD, 8'h11, 0, 8'h00);
      cmd(WD, 8'h22, 0, 8'h00);
      cmd(RA, 8'hFF, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'h11);
      cmd(RA, 8'h00, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'h22);
      @(negedge clk);
      check("t3_cmd_err", {7'b0, cmd_err}, 8'h00);

      // 4. Three back-to-back reads
      cmd(WA, 8'h40, 0, 8'h00);
      cmd(WD, 8'h5C, 0, 8'h00);
      cmd(RA, 8'h40, 0, 8'h00);
      for (int i = 0; i < 3; i++) cmd(RD, 8'h00, 1, 8'h5C);
      @(negedge clk);
      @(negedge clk);
      check("t4_valid_drop", {7'b0, tx_valid}, 8'h00);

      // 5. Write followed immediately by read of the same address
      cmd(RA, 8'h08, 0, 8'h00);
      cmd(WA, 8'h08, 0, 8'h00);
      cmd(WD, 8'h33, 0, 8'h00);
      cmd(WA, 8'h08, 0, 8'h00);
      cmd(WD, 8'h77, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'h77);

      // 6. Reset in the cycle after RD_DATA
      cmd(RD, 8'h00, 1, 8'h77);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("t6_async_valid", {7'b0, tx_valid}, 8'h00);
      check("t6_async_data", tx_data, 8'h00);
      check("t6_async_err", {7'b0, cmd_err}, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmd(RD, 8'h00, 0, 8'h00);
      @(negedge clk);
      check("t6_rdptr_invalid", {7'b0, cmd_err}, 8'h01);
      cmd(WD, 8'hEE, 0, 8'h00);      // wr_ptr invalid: must not write mem[0]
      cmd(RA, 8'h12, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'hA5);
      cmd(RA, 8'h00, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'h22);
      cmd(RA, 8'h40, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'h5C);
      cmd(RA, 8'h08, 0, 8'h00);
      cmd(RD, 8'h00, 1, 8'h77);
      repeat (4) @(negedge clk);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL missing_resp: %0d responses outstanding, required 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
